// File: rtl/rect_fetch.sv
// rect_fetch: reads the four rect words (x, y, w, h) of one Haar feature from
// the rect ROM, then derives the four integral-image corner addresses of that
// rect inside the detection window. It also flags rects that spill outside
// the window.
module rect_fetch #(
  parameter int unsigned W_DATA = 5,
  parameter int unsigned W_ADDR = 14,
  parameter int unsigned W_IDX  = 12,
  parameter int unsigned WIN    = 24,
  parameter int unsigned W_II   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [W_IDX-1:0]  req_idx,
  output logic              req_ready,
  output logic              rom_en,
  output logic [W_ADDR-1:0] rom_addr,
  input  logic [W_DATA-1:0] rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W_IDX-1:0]  out_idx,
  output logic [W_DATA-1:0] out_x,
  output logic [W_DATA-1:0] out_y,
  output logic [W_DATA-1:0] out_w,
  output logic [W_DATA-1:0] out_h,
  output logic [W_II-1:0]   out_a,
  output logic [W_II-1:0]   out_b,
  output logic [W_II-1:0]   out_c,
  output logic [W_II-1:0]   out_d,
  output logic              out_err
);

  // Integral image rows carry one extra zero column, so the row pitch is WIN+1.
  localparam int unsigned R = WIN + 1;

  typedef enum logic [2:0] {StIdle, StIssue, StDrain, StCalc, StOut} state_e;

  state_e              state_q;
  logic [W_IDX-1:0]    idx_q;
  logic [W_DATA-1:0]   x_q, y_q, w_q, h_q;
  logic                rd_vld_q;
  logic [1:0]          rd_k_q;

  logic [31:0]         x_full, y_full, w_full, h_full;
  logic [31:0]         row_top, row_bot;
  logic [W_II-1:0]     a_nxt, b_nxt, c_nxt, d_nxt;
  logic                err_nxt;

  assign req_ready = (state_q == StIdle);

  // Corner addresses and window check, computed at 32 bits then truncated.
  always_comb begin
    x_full  = 32'(x_q);
    y_full  = 32'(y_q);
    w_full  = 32'(w_q);
    h_full  = 32'(h_q);
    row_top = y_full * R;
    row_bot = (y_full + h_full) * R;
    a_nxt   = W_II'(row_top + x_full);
    b_nxt   = W_II'(row_top + x_full + w_full);
    c_nxt   = W_II'(row_bot + x_full);
    d_nxt   = W_II'(row_bot + x_full + w_full);
    err_nxt = ((x_full + w_full) > WIN) || ((y_full + h_full) > WIN);
  end

  // Capture each ROM word one cycle after its read; the low address bits
  // of the read tell which field it belongs to since the base is 4-aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_q <= 1'b0;
      rd_k_q   <= 2'd0;
      x_q      <= '0;
      y_q      <= '0;
      w_q      <= '0;
      h_q      <= '0;
    end else begin
      rd_vld_q <= rom_en;
      rd_k_q   <= rom_addr[1:0];
      if (rd_vld_q) begin
        unique case (rd_k_q)
          2'd0: x_q <= rom_data;
          2'd1: y_q <= rom_data;
          2'd2: w_q <= rom_data;
          2'd3: h_q <= rom_data;
        endcase
      end
    end
  end

  // Request FSM with registered ROM strobe and descriptor outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      rom_en    <= 1'b0;
      rom_addr  <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_x     <= '0;
      out_y     <= '0;
      out_w     <= '0;
      out_h     <= '0;
      out_a     <= '0;
      out_b     <= '0;
      out_c     <= '0;
      out_d     <= '0;
      out_err   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            idx_q    <= req_idx;
            rom_en   <= 1'b1;
            rom_addr <= W_ADDR'({req_idx, 2'b00});
            state_q  <= StIssue;
          end
        end
        StIssue: begin
          if (rom_addr[1:0] == 2'd3) begin
            rom_en  <= 1'b0;
            state_q <= StDrain;
          end else begin
            rom_addr <= rom_addr + W_ADDR'(1);
          end
        end
        StDrain: begin
          // h lands in its register at the end of this cycle.
          state_q <= StCalc;
        end
        StCalc: begin
          out_idx   <= idx_q;
          out_x     <= x_q;
          out_y     <= y_q;
          out_w     <= w_q;
          out_h     <= h_q;
          out_a     <= a_nxt;
          out_b     <= b_nxt;
          out_c     <= c_nxt;
          out_d     <= d_nxt;
          out_err   <= err_nxt;
          out_valid <= 1'b1;
          state_q   <= StOut;
        end
        StOut: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_fetch.sv
// Bench for rect_fetch: behavioural rect ROM, descriptor scoreboard queue,
// one task per scenario. Inputs driven and outputs sampled on the falling edge.
module tb_rect_fetch;

  typedef struct packed {
    logic [11:0] idx;
    logic [4:0]  x, y, w, h;
    logic [9:0]  a, b, c, d;
    logic        err;
  } desc_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [11:0] req_idx;
  logic        req_ready;
  logic        rom_en;
  logic [13:0] rom_addr;
  logic [4:0]  rom_data;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_idx;
  logic [4:0]  out_x, out_y, out_w, out_h;
  logic [9:0]  out_a, out_b, out_c, out_d;
  logic        out_err;

  logic [4:0]  mem [0:16383];
  desc_t       sb [$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  // Synchronous ROM: data valid the cycle after rom_en.
  always_ff @(posedge clk) if (rom_en) rom_data <= mem[rom_addr];

  rect_fetch dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_idx(req_idx), .req_ready(req_ready),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_x(out_x), .out_y(out_y), .out_w(out_w), .out_h(out_h),
    .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_d(out_d), .out_err(out_err)
  );

  function automatic desc_t obs();
    return {out_idx, out_x, out_y, out_w, out_h, out_a, out_b, out_c, out_d, out_err};
  endfunction

  // Reference descriptor computed from the ROM contents.
  function automatic desc_t model(input logic [11:0] idx);
    desc_t e;
    logic [13:0] base;
    int unsigned x, y, w, h;
    base  = {idx, 2'b00};
    e.idx = idx;
    e.x   = mem[base];
    e.y   = mem[base + 14'd1];
    e.w   = mem[base + 14'd2];
    e.h   = mem[base + 14'd3];
    x = e.x; y = e.y; w = e.w; h = e.h;
    e.a   = 10'(y * 25 + x);
    e.b   = 10'(y * 25 + x + w);
    e.c   = 10'((y + h) * 25 + x);
    e.d   = 10'((y + h) * 25 + x + w);
    e.err = (x + w > 24) || (y + h > 24);
    return e;
  endfunction

  // Offer a request for one cycle; returns in the cycle after the accept edge.
  task automatic accept(input logic [11:0] idx, input bit push);
    req_valid = 1'b1;
    req_idx   = idx;
    if (push) sb.push_back(model(idx));
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid; 'at' is the cycle number it was seen, -1 on timeout.
  task automatic await_out(input int start, output int at);
    at = start;
    while (!out_valid && at < start + 20) begin
      @(negedge clk);
      at++;
    end
    if (!out_valid) at = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_idx = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    checks++; if (rom_en !== 1'b0) begin errors++; $display("FAIL rst_rom_en got %b want 0", rom_en); end
    checks++; if (rom_addr !== 14'd0) begin errors++; $display("FAIL rst_rom_addr got %0d want 0", rom_addr); end
    checks++; if (obs() !== '0) begin errors++; $display("FAIL rst_outputs got %h want 0", obs()); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b want 1", req_ready); end
  endtask

  task automatic test_basic();
    desc_t e, o;
    int lat;
    out_ready = 1'b1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got %b want 1", req_ready); end
    accept(12'd0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rom_en !== 1'b1 || rom_addr !== 14'(k)) begin
        errors++; $display("FAIL basic_addr%0d got en=%b addr=%0d want en=1 addr=%0d", k, rom_en, rom_addr, k);
      end
      @(negedge clk);
    end
    checks++; if (rom_en !== 1'b0 || rom_addr !== 14'd3) begin
      errors++; $display("FAIL basic_drain got en=%b addr=%0d want en=0 addr=3", rom_en, rom_addr); end
    await_out(5, lat);
    checks++; if (lat != 7) begin errors++; $display("FAIL basic_latency got %0d want 7", lat); end
    e = sb.pop_front(); o = obs();
    checks++; if (o !== e) begin errors++; $display("FAIL basic_desc got %h want %h", o, e); end
    checks++; if (o.a !== 10'd106 || o.b !== 10'd118 || o.c !== 10'd331 || o.d !== 10'd343 || o.err !== 1'b0) begin
      errors++; $display("FAIL basic_corners got %0d %0d %0d %0d %b want 106 118 331 343 0", o.a, o.b, o.c, o.d, o.err); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL basic_release got valid=%b ready=%b want 0 1", out_valid, req_ready); end
    checks++; if (obs() !== o) begin errors++; $display("FAIL basic_hold got %h want %h", obs(), o); end
  endtask

  // Single request with out_ready high; checks latency and descriptor.
  task automatic test_feature(input logic [11:0] idx, input logic [9:0] ea, input logic [9:0] ed,
                              input logic eerr);
    desc_t e, o;
    int lat;
    out_ready = 1'b1;
    accept(idx, 1'b1);
    await_out(1, lat);
    checks++; if (lat != 7) begin errors++; $display("FAIL feat%0d_latency got %0d want 7", idx, lat); end
    e = sb.pop_front(); o = obs();
    checks++; if (o !== e) begin errors++; $display("FAIL feat%0d_desc got %h want %h", idx, o, e); end
    checks++; if (o.a !== ea || o.d !== ed || o.err !== eerr) begin
      errors++; $display("FAIL feat%0d_const got a=%0d d=%0d err=%b want a=%0d d=%0d err=%b",
                         idx, o.a, o.d, o.err, ea, ed, eerr); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    desc_t e, o;
    int lat;
    out_ready = 1'b0;
    accept(12'd0, 1'b1);
    await_out(1, lat);
    e = sb.pop_front();
    checks++; if (lat != 7) begin errors++; $display("FAIL bp_latency got %0d want 7", lat); end
    for (int i = 0; i < 5; i++) begin
      o = obs();
      checks++;
      if (o !== e || out_valid !== 1'b1 || req_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d got %h v=%b r=%b want %h v=1 r=0", i, o, out_valid, req_ready, e);
      end
      req_valid = (i % 2 == 0); req_idx = 12'd2;
      @(negedge clk);
    end
    req_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got valid=%b ready=%b want 0 1", out_valid, req_ready); end
    repeat (8) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || rom_en !== 1'b0) begin
        errors++; $display("FAIL bp_no_queue got valid=%b rom_en=%b want 0 0", out_valid, rom_en); end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    accept(12'd0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (rom_en !== 1'b0 || req_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rmid_abort got en=%b ready=%b valid=%b want 0 1 0", rom_en, req_ready, out_valid); end
    repeat (8) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_out got %b want 0", out_valid); end
    end
    test_feature(12'd0, 10'd106, 10'd343, 1'b0);
  endtask

  task automatic test_back_to_back();
    desc_t e;
    int lat;
    out_ready = 1'b1;
    accept(12'd2, 1'b1);
    await_out(1, lat);
    e = sb.pop_front();
    checks++; if (lat != 7 || obs() !== e) begin
      errors++; $display("FAIL b2b_first got lat=%0d %h want lat=7 %h", lat, obs(), e); end
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b want 1", req_ready); end
    accept(12'd5, 1'b1);
    await_out(9, lat);
    e = sb.pop_front();
    checks++; if (lat != 15 || obs() !== e) begin
      errors++; $display("FAIL b2b_second got lat=%0d %h want lat=15 %h", lat, obs(), e); end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 5'd0;
    mem[0]  = 5'h06; mem[1]  = 5'h04; mem[2]  = 5'h0c; mem[3]  = 5'h09;
    mem[8]  = 5'h03; mem[9]  = 5'h09; mem[10] = 5'h12; mem[11] = 5'h09;
    mem[20] = 5'd20; mem[21] = 5'd0;  mem[22] = 5'd8;  mem[23] = 5'd4;
    test_reset();
    test_basic();
    test_feature(12'd2, 10'd228, 10'd471, 1'b0);
    test_feature(12'd5, 10'd20, 10'd128, 1'b1);
    test_feature(12'd100, 10'd0, 10'd0, 1'b0);
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_empty got %0d want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
